// File: rtl/nn_fixed_pkg.sv
// Fixed-point types, widths and FSM states shared by the neuron pre-activation datapath.
// Optional build macro NEURON_ROUND_EN is consumed by neuron_round_sat.
package nn_fixed_pkg;

  localparam int INT_SIZE     = 3;
  localparam int FRC_SIZE     = 8;
  localparam int N_INPUTS_DEF = 8;
  localparam int W            = INT_SIZE + FRC_SIZE;

  // Two guard bits on top of the product-sum growth keep bias and rounding from overflowing.
  function automatic int acc_width(input int n);
    return 2 * W + $clog2(n) + 2;
  endfunction

  localparam int AW = acc_width(N_INPUTS_DEF);

  typedef logic signed [W-1:0] fix_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } state_t;

  localparam fix_t FIX_MAX = {1'b0, {(W-1){1'b1}}};
  localparam fix_t FIX_MIN = {1'b1, {(W-1){1'b0}}};

endpackage

// File: rtl/neuron_round_sat.sv
// Rescales the wide accumulator to Q(INT_SIZE).(FRC_SIZE) and clamps it to the output range.
// Define NEURON_ROUND_EN for round-half-up; otherwise the shift truncates toward -inf.
module neuron_round_sat
  import nn_fixed_pkg::*;
#(
  parameter int ACC_W = AW
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [W-1:0]     y,
  output logic                    sat
);

  localparam logic signed [ACC_W-1:0] MAX_EXT = ACC_W'(FIX_MAX);
  localparam logic signed [ACC_W-1:0] MIN_EXT = ACC_W'(FIX_MIN);

  logic signed [ACC_W-1:0] adjusted;
  logic signed [ACC_W-1:0] shifted;

`ifdef NEURON_ROUND_EN
  localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(1) << (FRC_SIZE - 1);
  assign adjusted = acc + HALF_LSB;
`else
  assign adjusted = acc;
`endif

  assign shifted = adjusted >>> FRC_SIZE;

  // NOTE: every output gets a default first, so no path through this block can infer a latch.
  always_comb begin
    y   = shifted[W-1:0];
    sat = 1'b0;
    if (shifted > MAX_EXT) begin
      y   = FIX_MAX;
      sat = 1'b1;
    end else if (shifted < MIN_EXT) begin
      y   = FIX_MIN;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/neuron_mac_accum.sv
// Sequential dot product of N_INPUTS (x,w) beats plus bias; the saturated result feeds tanh_function.X.
// Rounding mode is selected at build time by NEURON_ROUND_EN (see neuron_round_sat).
module neuron_mac_accum
  import nn_fixed_pkg::*;
#(
  parameter int N_INPUTS = N_INPUTS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [W-1:0] bias,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_x,
  input  logic signed [W-1:0] in_w,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_y,
  output logic                out_sat
);

  localparam int ACC_W = acc_width(N_INPUTS);
  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

  state_t                  state;
  state_t                  state_next;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic        [CNT_W-1:0] cnt;
  logic signed [2*W-1:0]   product;
  logic                    beat;
  logic                    last_beat;
  logic signed [W-1:0]     rs_y;
  logic                    rs_sat;

  assign product   = in_x * in_w;
  assign acc_sum   = acc + ACC_W'(product);
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (cnt == LAST);

  // The final beat is folded in combinationally so the result registers on the same edge.
  neuron_round_sat #(
    .ACC_W(ACC_W)
  ) u_round_sat (
    .acc(acc_sum),
    .y  (rs_y),
    .sat(rs_sat)
  );

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = ACCUM;
      end
      ACCUM: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid && (cnt == LAST)) state_next = OUTPUT;
      end
      OUTPUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      out_y   <= '0;
      out_sat <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        acc <= ACC_W'(bias) <<< FRC_SIZE;
        cnt <= '0;
      end
      if (beat) begin
        acc <= acc_sum;
        cnt <= cnt + CNT_W'(1);
      end
      if (last_beat) begin
        out_y   <= rs_y;
        out_sat <= rs_sat;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_accum.sv
// Self-checking bench for neuron_mac_accum: directed corner cases plus randomized dot products
// compared against an integer-arithmetic reference model.
module tb_neuron_mac_accum;
  import nn_fixed_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  fix_t bias = '0;
  logic busy;
  logic in_valid = 1'b0;
  logic in_ready;
  fix_t in_x = '0;
  fix_t in_w = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  fix_t out_y;
  logic out_sat;

  int checks = 0;
  int failures = 0;

  fix_t xv [N];
  fix_t wv [N];

  always #5 clk = ~clk;

  neuron_mac_accum #(.N_INPUTS(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bias     (bias),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_w     (in_w),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_sat  (out_sat)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: exact real-valued sum scaled by 2^FRC_SIZE, then floor (or round half up) and clamp.
  function automatic void model(input fix_t b, output fix_t y, output logic s);
    longint total;
    longint r;
    longint lo;
    longint hi;
    lo    = -(longint'(1) <<< (W - 1));
    hi    = (longint'(1) <<< (W - 1)) - 1;
    total = longint'(b) * (longint'(1) <<< FRC_SIZE);
    for (int i = 0; i < N; i++) total += longint'(xv[i]) * longint'(wv[i]);
`ifdef NEURON_ROUND_EN
    total += longint'(1) <<< (FRC_SIZE - 1);
`endif
    r = total >>> FRC_SIZE;
    s = 1'b0;
    if (r > hi) begin
      r = hi;
      s = 1'b1;
    end else if (r < lo) begin
      r = lo;
      s = 1'b1;
    end
    y = fix_t'(r);
  endfunction

  task automatic set_ops(input fix_t x0, input fix_t w0, input int n_active);
    for (int i = 0; i < N; i++) begin
      xv[i] = (i < n_active) ? x0 : fix_t'(0);
      wv[i] = (i < n_active) ? w0 : fix_t'(0);
    end
  endtask

  // One full transaction: start (with a stray in_valid that must not count), beats with optional
  // gaps and stray starts, result check, 'hold' cycles of back-pressure, then accept.
  task automatic run_txn(input string tag, input fix_t b, input int max_gap, input int hold,
                         input logic use_const, input fix_t cy, input logic cs);
    fix_t ey;
    logic es;
    model(b, ey, es);
    if (use_const) begin
      ey = cy;
      es = cs;
    end
    start    = 1'b1;
    bias     = b;
    in_valid = 1'b1;
    in_x     = fix_t'($urandom);
    in_w     = fix_t'($urandom);
    step();
    start    = 1'b0;
    in_valid = 1'b0;
    check({tag, ":busy_after_start"}, W'(busy), W'(1'b1));
    for (int i = 0; i < N; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int k = 0; k < gap; k++) begin
        in_valid = 1'b0;
        in_x     = fix_t'($urandom);
        in_w     = fix_t'($urandom);
        start    = 1'($urandom_range(0, 1));
        bias     = fix_t'($urandom);
        step();
      end
      in_valid = 1'b1;
      in_x     = xv[i];
      in_w     = wv[i];
      start    = (max_gap > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      bias     = fix_t'($urandom);
      step();
      in_valid = 1'b0;
      start    = 1'b0;
      check({tag, ":out_valid_timing"}, W'(out_valid), W'(i == N - 1));
    end
    check({tag, ":y"}, out_y, ey);
    check({tag, ":sat"}, W'(out_sat), W'(es));
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      start     = 1'($urandom_range(0, 1));
      in_valid  = 1'b1;
      in_x      = fix_t'($urandom);
      in_w      = fix_t'($urandom);
      step();
      check({tag, ":hold_valid"}, W'(out_valid), W'(1'b1));
      check({tag, ":hold_in_ready"}, W'(in_ready), W'(1'b0));
      check({tag, ":hold_y"}, out_y, ey);
      check({tag, ":hold_sat"}, W'(out_sat), W'(es));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    check({tag, ":accept_valid"}, W'(out_valid), W'(1'b0));
    check({tag, ":accept_busy"}, W'(busy), W'(1'b0));
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst:busy", W'(busy), W'(1'b0));
    check("rst:in_ready", W'(in_ready), W'(1'b0));
    check("rst:out_valid", W'(out_valid), W'(1'b0));
    check("rst:out_y", out_y, '0);
    check("rst:out_sat", W'(out_sat), W'(1'b0));
    rst = 1'b0;
    step();
    check("idle:busy", W'(busy), W'(1'b0));

    // Four beats of 1.0*0.5 then zeros -> 2.0
    set_ops(fix_t'(11'h100), fix_t'(11'h080), 4);
    run_txn("t1", '0, 0, 0, 1'b1, fix_t'(11'h200), 1'b0);

    // 8 * 3.0*3.0 = 72.0 -> positive clamp
    set_ops(fix_t'(11'h300), fix_t'(11'h300), N);
    run_txn("t2", '0, 1, 0, 1'b1, fix_t'(11'h3FF), 1'b1);

    // 8 * (-4.0)*3.0 = -96.0 -> negative clamp, then 5 cycles of back-pressure with stray inputs
    set_ops(fix_t'(11'h400), fix_t'(11'h300), N);
    run_txn("t3_t4", '0, 0, 5, 1'b1, fix_t'(11'h400), 1'b1);

    // Reset after two beats abandons the partial sum
    set_ops(fix_t'(11'h123), fix_t'(11'h0F0), N);
    start = 1'b1;
    bias  = fix_t'(11'h055);
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_x     = xv[i];
      in_w     = wv[i];
      step();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    check("t5:rst_busy", W'(busy), W'(1'b0));
    check("t5:rst_valid", W'(out_valid), W'(1'b0));
    check("t5:rst_in_ready", W'(in_ready), W'(1'b0));
    check("t5:rst_y", out_y, '0);
    rst = 1'b0;
    step();
    set_ops('0, '0, 0);
    run_txn("t5", fix_t'(11'h100), 0, 0, 1'b1, fix_t'(11'h100), 1'b0);

    // Sub-LSB results exercise the rounding mode
    set_ops(fix_t'(11'h001), fix_t'(11'h080), 1);
`ifdef NEURON_ROUND_EN
    run_txn("t6a", '0, 0, 0, 1'b1, fix_t'(11'h001), 1'b0);
`else
    run_txn("t6a", '0, 0, 0, 1'b1, fix_t'(11'h000), 1'b0);
`endif
    set_ops(fix_t'(11'h7FF), fix_t'(11'h080), 1);
`ifdef NEURON_ROUND_EN
    run_txn("t6b", '0, 0, 0, 1'b1, fix_t'(11'h000), 1'b0);
`else
    run_txn("t6b", '0, 0, 0, 1'b1, fix_t'(11'h7FF), 1'b0);
`endif

    // Randomized transactions: small operands (mostly in range) and full-range (often clamped)
    for (int t = 0; t < 30; t++) begin
      fix_t b;
      if (t % 2 == 0) begin
        for (int i = 0; i < N; i++) begin
          xv[i] = fix_t'(int'($urandom_range(0, 256)) - 128);
          wv[i] = fix_t'(int'($urandom_range(0, 256)) - 128);
        end
        b = fix_t'(int'($urandom_range(0, 512)) - 256);
      end else begin
        for (int i = 0; i < N; i++) begin
          xv[i] = fix_t'($urandom);
          wv[i] = fix_t'($urandom);
        end
        b = fix_t'($urandom);
      end
      run_txn($sformatf("rnd%0d", t), b, 2, int'($urandom_range(0, 3)), 1'b0, '0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
